// File: rtl/mem_stage_ctrl_if.sv
// X/M inputs, data-memory handshake and registered M/W outputs of the memory-stage controller.
// master is the controller's side; slave is the pipeline/memory environment's side.
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [15:0]       XM_aluOut;
  logic [15:0]       XM_writeData;
  logic [15:0]       XM_pc_inc;
  logic [15:0]       XM_specOps;
  logic              XM_memRead;
  logic              XM_memWrite;
  logic              XM_memAccess;
  logic [1:0]        XM_regSrc;
  logic              XM_regWrite;
  logic [2:0]        XM_writeReg;
  logic              XM_halt;

  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [15:0]       mem_rdata;
  logic              mem_done;

  logic              stall_out;
  logic [15:0]       MW_wbData;
  logic              MW_regWrite;
  logic [2:0]        MW_writeReg;
  logic              MW_halt;
  logic              MW_err;

  modport master (
    input  XM_aluOut, XM_writeData, XM_pc_inc, XM_specOps, XM_memRead, XM_memWrite,
           XM_memAccess, XM_regSrc, XM_regWrite, XM_writeReg, XM_halt,
           mem_rdata, mem_done,
    output mem_addr, mem_wdata, mem_rd, mem_wr, stall_out,
           MW_wbData, MW_regWrite, MW_writeReg, MW_halt, MW_err
  );

  modport slave (
    output XM_aluOut, XM_writeData, XM_pc_inc, XM_specOps, XM_memRead, XM_memWrite,
           XM_memAccess, XM_regSrc, XM_regWrite, XM_writeReg, XM_halt,
           mem_rdata, mem_done,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, stall_out,
           MW_wbData, MW_regWrite, MW_writeReg, MW_halt, MW_err
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues X/M loads/stores, stalls until mem_done (TIMEOUT -> sticky ERR), registers M/W.
// Optional MEM_ALIGN_CHECK_EN: odd-address access issues no request and traps to ERR.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  mem_stage_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ERR = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] MW_wbData_q, MW_wbData_d;
  logic        MW_regWrite_q, MW_regWrite_d;
  logic [2:0]  MW_writeReg_q, MW_writeReg_d;
  logic        MW_halt_q, MW_halt_d;
  logic        MW_err_q, MW_err_d;

  logic        acc, is_rd, is_wr, misalign;
  logic        req, stall, complete;
  logic [15:0] wb_sel;

  assign acc   = bus.XM_memAccess & (bus.XM_memRead | bus.XM_memWrite);
  assign is_rd = bus.XM_memRead;
  assign is_wr = bus.XM_memWrite & ~bus.XM_memRead;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = acc & bus.XM_aluOut[0];
`else
  assign misalign = 1'b0;
`endif

  assign bus.mem_addr  = ADDR_W'(bus.XM_aluOut);
  assign bus.mem_wdata = bus.XM_writeData;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (misalign) begin
          stall   = 1'b1;
          state_d = ERR;
        end else if (acc) begin
          req = 1'b1;
          if (bus.mem_done) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = WAIT;
            cnt_d   = 8'd0;
          end
        end else begin
          complete = 1'b1;
        end
      end
      WAIT: begin
        req   = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (bus.mem_done) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt_q == 8'(TIMEOUT - 1)) state_d = ERR;
        end
      end
      default: begin
        stall   = 1'b1;
        state_d = ERR;
      end
    endcase
  end

  // Reset must kill requests and stall immediately, before the state register settles.
  assign bus.mem_rd    = req & is_rd & ~rst;
  assign bus.mem_wr    = req & is_wr & ~rst;
  assign bus.stall_out = stall & ~rst;

  always_comb begin
    wb_sel = bus.XM_aluOut;
    case (bus.XM_regSrc)
      2'b00:   wb_sel = bus.XM_aluOut;
      2'b01:   wb_sel = bus.mem_rdata;
      2'b10:   wb_sel = bus.XM_pc_inc;
      default: wb_sel = bus.XM_specOps;
    endcase
  end

  // Non-completing cycles insert a bubble; data and destination simply hold.
  always_comb begin
    MW_wbData_d   = MW_wbData_q;
    MW_writeReg_d = MW_writeReg_q;
    MW_regWrite_d = 1'b0;
    MW_halt_d     = 1'b0;
    MW_err_d      = MW_err_q | (state_d == ERR);
    if (complete) begin
      MW_wbData_d   = wb_sel;
      MW_writeReg_d = bus.XM_writeReg;
      MW_regWrite_d = bus.XM_regWrite;
      MW_halt_d     = bus.XM_halt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      MW_wbData_q   <= 16'd0;
      MW_regWrite_q <= 1'b0;
      MW_writeReg_q <= 3'd0;
      MW_halt_q     <= 1'b0;
      MW_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      MW_wbData_q   <= MW_wbData_d;
      MW_regWrite_q <= MW_regWrite_d;
      MW_writeReg_q <= MW_writeReg_d;
      MW_halt_q     <= MW_halt_d;
      MW_err_q      <= MW_err_d;
    end
  end

  assign bus.MW_wbData   = MW_wbData_q;
  assign bus.MW_regWrite = MW_regWrite_q;
  assign bus.MW_writeReg = MW_writeReg_q;
  assign bus.MW_halt     = MW_halt_q;
  assign bus.MW_err      = MW_err_q;
endmodule
